// File: rtl/priority_seq_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_seq_fsm_if
// Description : Control/status bundle between the register bank (master) and
//               the priority channel sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_seq_fsm_if #(
    parameter int N_CH    = 16,
    parameter int DWELL_W = 8
);
    localparam int IDX_W = $clog2(N_CH);

    logic [N_CH-1:0]    ch_mask_i;
    logic               arm_i;
    logic               dump_i;
    logic               inter_i;
    logic               disable_i;
    logic               mode_i;
    logic [DWELL_W-1:0] dwell_i;

    logic [N_CH-1:0]    ch_sel_o;
    logic [IDX_W-1:0]   ch_idx_o;
    logic [N_CH-1:0]    pending_o;
    logic               idle_sm_o;
    logic               cycle_done_o;

    modport master (
        output ch_mask_i, arm_i, dump_i, inter_i, disable_i, mode_i, dwell_i,
        input  ch_sel_o, ch_idx_o, pending_o, idle_sm_o, cycle_done_o
    );

    modport slave (
        input  ch_mask_i, arm_i, dump_i, inter_i, disable_i, mode_i, dwell_i,
        output ch_sel_o, ch_idx_o, pending_o, idle_sm_o, cycle_done_o
    );
endinterface
`default_nettype wire

// File: rtl/priority_seq_fsm.sv
`default_nettype none
// ============================================================================
// Module      : priority_seq_fsm
// Description : N-channel priority sequencer. Latches a channel mask on arm,
//               serves the lowest-index pending channel on each dump for a
//               programmable dwell, with one-shot/auto-repeat, hold/resume
//               and hard disable.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_seq_fsm #(
    parameter int N_CH    = 16,
    parameter int DWELL_W = 8
) (
    input  wire logic          clk_i,
    input  wire logic          resetn_i,
    priority_seq_fsm_if.slave  bus
);
    localparam int IDX_W = $clog2(N_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DWELL = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_arm_q;
    logic               r_dump_q;
    logic [N_CH-1:0]    r_pending;
    logic [N_CH-1:0]    r_mask_lat;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [IDX_W-1:0]   r_ch_idx;
    logic [N_CH-1:0]    r_ch_sel;
    logic               r_done;
    logic               r_idle;

    logic               w_arm_rise;
    logic               w_dump_rise;
    logic               w_mask_nz;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [N_CH-1:0]    w_pick_sel;
    logic [N_CH-1:0]    w_retired;

    assign w_arm_rise  = bus.arm_i  & ~r_arm_q;
    assign w_dump_rise = bus.dump_i & ~r_dump_q;
    assign w_mask_nz   = |bus.ch_mask_i;
    assign w_retired   = r_pending & ~r_ch_sel;

    // Priority encoder: lowest set index of the pending set wins.
    always_comb begin
        w_pick_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_idx = IDX_W'(i);
            end
        end
        w_pick_sel = (|r_pending) ? (N_CH'(1) << w_pick_idx) : '0;
    end

    // Sequencer state machine; every output is a register written here.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state     <= ST_IDLE;
            r_arm_q     <= 1'b0;
            r_dump_q    <= 1'b0;
            r_pending   <= '0;
            r_mask_lat  <= '0;
            r_dwell_cnt <= '0;
            r_ch_idx    <= '0;
            r_ch_sel    <= '0;
            r_done      <= 1'b0;
            r_idle      <= 1'b1;
        end else begin
            r_arm_q  <= bus.arm_i;
            r_dump_q <= bus.dump_i;
            r_done   <= 1'b0;

            if (bus.disable_i) begin
                r_state   <= ST_IDLE;
                r_idle    <= 1'b1;
                r_pending <= '0;
                r_ch_sel  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_arm_rise && w_mask_nz) begin
                            r_mask_lat <= bus.ch_mask_i;
                            r_pending  <= bus.ch_mask_i;
                            r_state    <= ST_ARMED;
                            r_idle     <= 1'b0;
                        end
                    end
                    ST_ARMED: begin
                        if (bus.inter_i) begin
                            r_state <= ST_HOLD;
                        end else if (w_dump_rise) begin
                            // A dump with nothing pending has nothing to select.
                            if (|r_pending) begin
                                r_ch_sel    <= w_pick_sel;
                                r_ch_idx    <= w_pick_idx;
                                r_dwell_cnt <= bus.dwell_i;
                                r_state     <= ST_DWELL;
                            end
                        end else if (w_arm_rise && w_mask_nz) begin
                            r_mask_lat <= bus.ch_mask_i;
                            r_pending  <= bus.ch_mask_i;
                        end
                    end
                    ST_DWELL: begin
                        if (bus.inter_i) begin
                            // Channel stays pending; remaining dwell is dropped.
                            r_ch_sel <= '0;
                            r_state  <= ST_HOLD;
                        end else if (r_dwell_cnt == '0) begin
                            r_ch_sel <= '0;
                            if (|w_retired) begin
                                r_pending <= w_retired;
                                r_state   <= ST_ARMED;
                            end else begin
                                r_done <= 1'b1;
                                if (bus.mode_i) begin
                                    r_pending <= r_mask_lat;
                                    r_state   <= ST_ARMED;
                                end else begin
                                    r_pending <= '0;
                                    r_state   <= ST_IDLE;
                                    r_idle    <= 1'b1;
                                end
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt - 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        // Resume keeps the existing pending set; no mask reload.
                        if (!bus.inter_i && w_arm_rise) begin
                            r_state <= ST_ARMED;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_idle  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ch_sel_o     = r_ch_sel;
    assign bus.ch_idx_o     = r_ch_idx;
    assign bus.pending_o    = r_pending;
    assign bus.idle_sm_o    = r_idle;
    assign bus.cycle_done_o = r_done;

endmodule
`default_nettype wire

// File: doc/priority_seq_fsm.md
# priority_seq_fsm

Parametrised channel sequencer: latches a channel mask on arm, then on each dump request selects the highest-priority pending channel, with index 0 highest. The selected channel's one-hot select is driven for a programmable dwell time, and the channel is then retired. It supports one-shot and auto-repeat modes, a hold/resume interrupt and a hard disable. It sits between the control register bank and the channel switch matrix, and is the N-channel, dwell-capable successor of the fixed 16-channel priority FSM.

## Interface
- N_CH, 16, number of channels (2..64)
- DWELL_W, 8, width of dwell count
- clk_i  in  1  system clock, all state on rising edge
- resetn_i  in  1  asynchronous, active-low reset
- ch_mask_i  in  N_CH  channels to serve, sampled on arm
- arm_i  in  1  arm request (rising-edge detected internally)
- dump_i  in  1  step request (rising-edge detected internally)
- inter_i  in  1  interrupt: hold sequence (level, sampled each cycle)
- disable_i  in  1  abort to idle (level, sampled each cycle)
- mode_i  in  1  0 = one-shot, 1 = auto-repeat; sampled at the end of the cycle
- dwell_i  in  DWELL_W  select hold length minus 1, sampled on dump
- ch_sel_o  out  N_CH  one-hot selected channel, or all-zero
- ch_idx_o  out  $clog2(N_CH)  index of the current or last selected channel
- pending_o  out  N_CH  channels not yet served this cycle
- idle_sm_o  out  1  high in IDLE
- cycle_done_o  out  1  one-cycle pulse when the pending set empties

## Operation
- Edge detect: arm_rise = arm_i & ~arm_q; dump_rise = dump_i & ~dump_q. arm_q and dump_q are registered every cycle, including during reset release.
- Registers: state, pending, mask_lat, dwell_cnt, ch_idx, ch_sel, done pulse.
- States:
  - IDLE
  - ARMED: waiting for dump
  - DWELL: channel selected
  - HOLD: interrupted
- IDLE:
  - arm_rise with ch_mask_i != 0: mask_lat and pending load ch_mask_i; go to ARMED.
  - arm_rise with ch_mask_i == 0: ignored.
- ARMED:
  - dump_rise: pick the lowest set index of pending; set ch_sel to one-hot of it, ch_idx to the index, dwell_cnt to dwell_i; go to DWELL.
  - arm_rise with nonzero mask: reloads mask_lat and pending, stays in ARMED.
  - If dump_rise and arm_rise coincide, dump wins and arm is dropped.
- DWELL:
  - dwell_cnt decrements each cycle. The cycle in which it equals 0 is the last select cycle.
  - At the end of that cycle: ch_sel clears and the selected bit clears from pending.
  - If the new pending is nonzero: go to ARMED.
  - If the new pending is empty: assert cycle_done for one cycle. With mode_i=0, go to IDLE. With mode_i=1, reload pending from mask_lat and go to ARMED.
  - arm_rise and dump_rise are ignored in DWELL.
- HOLD:
  - Entered from ARMED or DWELL when inter_i=1.
  - On entry, ch_sel clears; the interrupted channel remains in pending and is re-served later.
  - dwell_cnt is discarded.
  - arm_rise resumes to ARMED without reloading the mask. dump is ignored.
- disable_i=1 in any state forces the next state to IDLE, clears pending and ch_sel, and suppresses cycle_done.
- Priority of simultaneous events: disable > inter > end-of-dwell > dump > arm.
  - If inter coincides with the last dwell cycle, inter wins: the channel is not retired and no done pulse is produced.

## Timing
- Reset values:
  - ch_sel_o = 0, ch_idx_o = 0, pending_o = 0, cycle_done_o = 0
  - idle_sm_o = 1, state = IDLE
  - arm_q = dump_q = 0
- All outputs are registered; none has a combinational path from an input.
- arm_i high at edge t (low at t-1): pending_o valid and idle_sm_o = 0 from t+1.
- dump_i rising sampled at edge t: ch_sel_o asserted for cycles t+1 .. t+1+dwell_i, i.e. dwell_i+1 cycles.
  - ch_sel_o = 0 and the pending bit cleared from t+2+dwell_i.
  - cycle_done_o high exactly in cycle t+2+dwell_i, if the pending set emptied.
- inter_i or disable_i sampled at edge t: ch_sel_o = 0 from t+1.
- The minimum gap between two selections is one all-zero cycle, so ch_sel_o is never one-hot for two different channels back to back.
- Reset asserted mid-DWELL: all outputs return to reset values immediately, asynchronously. First arm is accepted one cycle after deassertion.
- Width: ch_idx_o is $clog2(N_CH) bits. Dwell never wraps; dwell_i = 2^DWELL_W - 1 gives 2^DWELL_W select cycles.

## Test plan
- Reset, then arm with mask 0x0022, dwell 0, mode 0, then three dumps:
  - First dump: ch_sel 0x0002, then ch_idx 1 for 1 cycle.
  - Second dump: 0x0020, then idx 5; cycle_done pulses; idle_sm_o returns to 1.
  - Third dump: no selection.
- Mask 0xF040, dwell 3, mode 1, five dumps:
  - Sequence is 0x0040, 0x1000, 0x2000, 0x4000, 0x8000.
  - Each selection is held 4 cycles.
  - cycle_done pulses after 0x8000; pending_o reloads to 0xF040; idle stays 0.
- Interrupt mid-dwell on channel 6 (mask 0x00C0, dwell 5): pulse inter during the 3rd select cycle.
  - ch_sel drops next cycle; pending_o stays 0x00C0.
  - arm resumes; next dump reselects 0x0040 for the full 6 cycles.
- disable_i on the same cycle as dump_i in ARMED: no selection; pending_o = 0; idle_sm_o = 1; no cycle_done.
- Async reset asserted during DWELL: all outputs match their reset values within the same cycle; a subsequent arm with mask 0x0001 and a dump selects 0x0001.
- N_CH = 4 build, mask 0x0, arm: state stays IDLE. Then arm with mask 0x8 and dump: ch_sel 0x8, ch_idx 3.
